// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_if
// Brief  : Pipeline-side signal bundle for the hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
   parameter int REG_W = 5
);
   logic [REG_W-1:0] Rs1D;
   logic [REG_W-1:0] Rs2D;
   logic [REG_W-1:0] Rs1E;
   logic [REG_W-1:0] Rs2E;
   logic [REG_W-1:0] RdE;
   logic [REG_W-1:0] RdM;
   logic [REG_W-1:0] RdW;
   logic [1:0]       ResultSrcE;
   logic             RegWriteM;
   logic             RegWriteW;
   logic             PCSrcE;
   logic             MemReqM;
   logic             MemAckM;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             StallM;
   logic             FlushD;
   logic             FlushE;
   logic             FlushW;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic             MemErr;

   // Pipeline datapath side
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, MemErr
   );

   // Hazard controller side
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, MemErr
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : Forwarding, load-use stall, branch flush and data-memory wait FSM
//          with timeout halt. Optional perf counters: HAZARD_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  logic               clk,
   input  logic               rst,
   hazard_ctrl_if.slave       bus
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]        LoadStallCnt,
   output logic [31:0]        MemStallCnt,
   output logic [31:0]        FlushCnt
`endif
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_HALT     = 2'd2
   } state_t;

   localparam logic [REG_W-1:0] ZERO_REG = '0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             memerr_q, memerr_d;

   logic lw_stall;
   logic mem_stall;
   logic halted;
   logic lw_apply;
   logic flush_apply;

   // Forwarding: M stage outranks W since it holds the younger result
   always_comb begin
      bus.ForwardAE = 2'b00;
      bus.ForwardBE = 2'b00;
      if (bus.RegWriteM && (bus.RdM != ZERO_REG) && (bus.RdM == bus.Rs1E))
         bus.ForwardAE = 2'b10;
      else if (bus.RegWriteW && (bus.RdW != ZERO_REG) && (bus.RdW == bus.Rs1E))
         bus.ForwardAE = 2'b01;
      if (bus.RegWriteM && (bus.RdM != ZERO_REG) && (bus.RdM == bus.Rs2E))
         bus.ForwardBE = 2'b10;
      else if (bus.RegWriteW && (bus.RdW != ZERO_REG) && (bus.RdW == bus.Rs2E))
         bus.ForwardBE = 2'b01;
   end

   assign lw_stall  = (bus.ResultSrcE == 2'b01) && (bus.RdE != ZERO_REG) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
   assign mem_stall = ((state_q == S_RUN) && bus.MemReqM && !bus.MemAckM) ||
                      ((state_q == S_MEM_WAIT) && !bus.MemAckM);
   assign halted    = (state_q == S_HALT);
   assign flush_apply = !halted && !mem_stall && bus.PCSrcE;
   assign lw_apply    = !halted && !mem_stall && !bus.PCSrcE && lw_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_RUN;
         cnt_q    <= '0;
         memerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         memerr_q <= memerr_d;
      end
   end

   // The FSM does not look at MemReqM once waiting; a dropped request keeps waiting
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      memerr_d = memerr_q;
      case (state_q)
         S_RUN: begin
            if (bus.MemReqM && !bus.MemAckM) begin
               state_d = S_MEM_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         S_MEM_WAIT: begin
            if (bus.MemAckM) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_HALT;
               memerr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      bus.StallF = 1'b0;
      bus.StallD = 1'b0;
      bus.StallE = 1'b0;
      bus.StallM = 1'b0;
      bus.FlushD = 1'b0;
      bus.FlushE = 1'b0;
      bus.FlushW = 1'b0;
      if (rst) begin
         bus.FlushD = 1'b1;
         bus.FlushE = 1'b1;
         bus.FlushW = 1'b1;
      end else if (halted || mem_stall) begin
         bus.StallF = 1'b1;
         bus.StallD = 1'b1;
         bus.StallE = 1'b1;
         bus.StallM = 1'b1;
         bus.FlushW = 1'b1;
      end else if (bus.PCSrcE) begin
         bus.FlushD = 1'b1;
         bus.FlushE = 1'b1;
      end else if (lw_stall) begin
         bus.StallF = 1'b1;
         bus.StallD = 1'b1;
         bus.FlushE = 1'b1;
      end
   end

   assign bus.MemErr = memerr_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] ldcnt_q, memcnt_q, flcnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ldcnt_q  <= '0;
         memcnt_q <= '0;
         flcnt_q  <= '0;
      end else begin
         if (lw_apply)    ldcnt_q  <= ldcnt_q + 32'd1;
         if (mem_stall)   memcnt_q <= memcnt_q + 32'd1;
         if (flush_apply) flcnt_q  <= flcnt_q + 32'd1;
      end
   end

   assign LoadStallCnt = ldcnt_q;
   assign MemStallCnt  = memcnt_q;
   assign FlushCnt     = flcnt_q;
`else
   logic unused_apply;
   assign unused_apply = lw_apply ^ flush_apply;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int REG_W = 5;

   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
   localparam logic [6:0] CTL_NONE  = 7'b0000_000;
   localparam logic [6:0] CTL_RST   = 7'b0000_111;
   localparam logic [6:0] CTL_LW    = 7'b1100_010;
   localparam logic [6:0] CTL_BR    = 7'b0000_110;
   localparam logic [6:0] CTL_MEM   = 7'b1111_001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   hazard_ctrl_if #(.REG_W(REG_W)) bus ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] LoadStallCnt, MemStallCnt, FlushCnt;
`endif

   hazard_ctrl #(
      .REG_W       (REG_W),
      .MEM_TIMEOUT (8),
      .CNT_W       (7)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .LoadStallCnt (LoadStallCnt),
      .MemStallCnt  (MemStallCnt),
      .FlushCnt     (FlushCnt)
`endif
   );

   always #5 clk = ~clk;

   logic [6:0] ctl;
   assign ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                 bus.FlushD, bus.FlushE, bus.FlushW};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
      bus.RdE = '0;  bus.RdM = '0;  bus.RdW = '0;
      bus.ResultSrcE = 2'b00;
      bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
      bus.PCSrcE = 1'b0; bus.MemReqM = 1'b0; bus.MemAckM = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if (ctl !== CTL_RST) begin
         $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RST); n_bad++;
      end
      n_cmp++;
      if ({bus.ForwardAE, bus.ForwardBE, bus.MemErr} !== 5'b0) begin
         $display("FAIL reset_fwd_err: got %b want 00000",
                  {bus.ForwardAE, bus.ForwardBE, bus.MemErr}); n_bad++;
      end
      tick();
      rst = 1'b0;
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL reset_release: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
   endtask

   task automatic test_forwarding();
      tick();
      clear_inputs();
      bus.RegWriteM = 1'b1; bus.RdM = 5'd5;
      bus.RegWriteW = 1'b1; bus.RdW = 5'd5;
      bus.Rs1E = 5'd5; bus.Rs2E = 5'd0;
      #2;
      n_cmp++;
      if (bus.ForwardAE !== 2'b10) begin
         $display("FAIL fwd_m_prio: got %b want 10", bus.ForwardAE); n_bad++;
      end
      bus.RdM = 5'd0;
      #1;
      n_cmp++;
      if (bus.ForwardAE !== 2'b01) begin
         $display("FAIL fwd_w: got %b want 01", bus.ForwardAE); n_bad++;
      end
      bus.RdW = 5'd0;
      #1;
      n_cmp++;
      if (bus.ForwardBE !== 2'b00) begin
         $display("FAIL fwd_x0: got %b want 00", bus.ForwardBE); n_bad++;
      end
      bus.RdM = 5'd9; bus.Rs2E = 5'd9; bus.RegWriteM = 1'b0;
      bus.RdW = 5'd9;
      #1;
      n_cmp++;
      if (bus.ForwardBE !== 2'b01) begin
         $display("FAIL fwd_b_w_nowrm: got %b want 01", bus.ForwardBE); n_bad++;
      end
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL fwd_no_ctl: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
   endtask

   task automatic test_load_use();
      tick();
      clear_inputs();
      bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7; bus.Rs1D = 5'd3;
      #2;
      n_cmp++;
      if (ctl !== CTL_LW) begin
         $display("FAIL lw_stall: got %b want %b", ctl, CTL_LW); n_bad++;
      end
      tick();
      bus.RdE = 5'd0; bus.ResultSrcE = 2'b00;
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL lw_bubble: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
      bus.ResultSrcE = 2'b01; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL lw_x0: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
   endtask

   task automatic test_branch();
      tick();
      clear_inputs();
      bus.PCSrcE = 1'b1;
      #2;
      n_cmp++;
      if (ctl !== CTL_BR) begin
         $display("FAIL br_flush: got %b want %b", ctl, CTL_BR); n_bad++;
      end
      tick();
      bus.ResultSrcE = 2'b01; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
      #2;
      n_cmp++;
      if (ctl !== CTL_BR) begin
         $display("FAIL br_over_lw: got %b want %b", ctl, CTL_BR); n_bad++;
      end
      tick();
      clear_inputs();
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL br_after: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
   endtask

   task automatic test_mem_wait();
      int stalls;
      stalls = 0;
      tick();
      clear_inputs();
      bus.MemReqM = 1'b1;
      bus.PCSrcE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         if (ctl === CTL_MEM) stalls++;
         tick();
      end
      n_cmp++;
      if (stalls !== 3) begin
         $display("FAIL mem_stall_cycles: got %0d want 3", stalls); n_bad++;
      end
      bus.MemAckM = 1'b1;
      bus.PCSrcE = 1'b0;
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL mem_ack_release: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
      tick();
      bus.MemReqM = 1'b1; bus.MemAckM = 1'b1;
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL mem_zero_wait: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
      tick();
      clear_inputs();
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL mem_after_zero_wait: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
   endtask

   task automatic test_timeout();
      int stalls;
      stalls = 0;
      tick();
      clear_inputs();
      bus.MemReqM = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #2;
         if (ctl === CTL_MEM && bus.MemErr === 1'b0) stalls++;
         tick();
      end
      n_cmp++;
      if (stalls !== 8) begin
         $display("FAIL to_stall_cycles: got %0d want 8", stalls); n_bad++;
      end
      n_cmp++;
      if (bus.MemErr !== 1'b1) begin
         $display("FAIL to_memerr: got %b want 1", bus.MemErr); n_bad++;
      end
      bus.MemAckM = 1'b1;
      bus.MemReqM = 1'b0;
      bus.PCSrcE = 1'b1;
      tick();
      #1;
      n_cmp++;
      if ({ctl, bus.MemErr} !== {CTL_MEM, 1'b1}) begin
         $display("FAIL to_halt_hold: got %b want %b", {ctl, bus.MemErr},
                  {CTL_MEM, 1'b1}); n_bad++;
      end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ctl, bus.MemErr} !== {CTL_RST, 1'b0}) begin
         $display("FAIL to_rst_async: got %b want %b", {ctl, bus.MemErr},
                  {CTL_RST, 1'b0}); n_bad++;
      end
      tick();
      clear_inputs();
      rst = 1'b0;
      #2;
      n_cmp++;
      if ({ctl, bus.MemErr} !== {CTL_NONE, 1'b0}) begin
         $display("FAIL to_run_after_rst: got %b want %b", {ctl, bus.MemErr},
                  {CTL_NONE, 1'b0}); n_bad++;
      end
   endtask

   task automatic test_reset_mid_wait();
      tick();
      clear_inputs();
      bus.MemReqM = 1'b1;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== CTL_RST) begin
         $display("FAIL rmw_flush_only: got %b want %b", ctl, CTL_RST); n_bad++;
      end
`ifdef HAZARD_PERF_CNT_EN
      n_cmp++;
      if ({LoadStallCnt, MemStallCnt, FlushCnt} !== 96'd0) begin
         $display("FAIL rmw_perf_zero: got %0d %0d %0d want 0 0 0",
                  LoadStallCnt, MemStallCnt, FlushCnt); n_bad++;
      end
`endif
      tick();
      clear_inputs();
      rst = 1'b0;
      #2;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         $display("FAIL rmw_state_run: got %b want %b", ctl, CTL_NONE); n_bad++;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller. Generates the stall, flush (clear) and forwarding selects consumed by the fetch, decode, execute and memory pipeline registers.
- Detects three hazards:
  - RAW forwarding from the M and W stages.
  - Load-use stalls.
  - Taken branch/jump flushes.
- Sequences multi-cycle data-memory waits with an FSM and a timeout counter. A timeout halts the core with a sticky error.

Parameters:
- REG_W, 5, register-address width.
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before the error halt (must be ≥2).
- CNT_W, 7, wait-counter width; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- Rs1D  in  REG_W  source reg 1 of the instruction in decode.
- Rs2D  in  REG_W  source reg 2 of the instruction in decode.
- Rs1E  in  REG_W  source reg 1 of the instruction in execute.
- Rs2E  in  REG_W  source reg 2 of the instruction in execute.
- RdE  in  REG_W  destination reg in execute.
- RdM  in  REG_W  destination reg in memory.
- RdW  in  REG_W  destination reg in writeback.
- ResultSrcE  in  2  result select in execute; 2'b01 = load.
- RegWriteM  in  1  M-stage instruction writes the register file.
- RegWriteW  in  1  W-stage instruction writes the register file.
- PCSrcE  in  1  taken branch/jump resolved in execute.
- MemReqM  in  1  M-stage load/store access is active.
- MemAckM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold the PC.
- StallD  out  1  hold the fetch→decode register.
- StallE  out  1  hold the decode→execute register.
- StallM  out  1  hold the execute→memory register.
- FlushD  out  1  clear the fetch→decode register.
- FlushE  out  1  clear the decode→execute register.
- FlushW  out  1  clear the memory→writeback register.
- ForwardAE  out  2  ALU operand A source: 00 = reg file, 01 = W result, 10 = M ALU result.
- ForwardBE  out  2  ALU operand B source, same encoding as ForwardAE.
- MemErr  out  1  sticky memory-timeout error.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State → RUN, wait counter → 0, MemErr → 0.
  - While rst=1: FlushD=FlushE=FlushW=1, all Stall*=0, Forward*=00.
- Forwarding (combinational, every state):
  - ForwardAE=10 if RegWriteM and RdM≠0 and RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW and RdW≠0 and RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE is identical using Rs2E.
  - M takes priority over W.
- Load-use detect (lwStall): ResultSrcE==01 and RdE≠0 and (RdE==Rs1D or RdE==Rs2D).
- memStall is asserted when either holds:
  - state==RUN and MemReqM and !MemAckM; or
  - state==MEM_WAIT and !MemAckM.
- Output priority, highest first (rst excepted):
  - HALT: all Stall*=1, FlushW=1, FlushD=FlushE=0.
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1; no other flush. PCSrcE and lwStall are ignored because E is frozen; they are re-evaluated once released.
  - PCSrcE: FlushD=1, FlushE=1, no stalls.
  - lwStall: StallF=StallD=1, FlushE=1. This gives one bubble.
  - Otherwise all Stall*/Flush* are 0.
- FSM states: RUN, MEM_WAIT, HALT.
- Transitions:
  - RUN → MEM_WAIT: MemReqM and !MemAckM; counter ← 1.
  - RUN stays RUN on a same-cycle ack; zero-wait access, no stall.
  - MEM_WAIT → RUN: MemAckM=1. Stalls drop in that same cycle (combinational on ack) and the counter clears.
  - MEM_WAIT, no ack, counter < MEM_TIMEOUT-1: counter increments.
  - MEM_WAIT, no ack, counter == MEM_TIMEOUT-1: → HALT, MemErr ← 1.
  - HALT: absorbing until rst. MemAckM is ignored.
- Stall latency:
  - The first wait cycle stalls combinationally, with zero registered latency.
  - A request held for N cycles without ack (N < MEM_TIMEOUT) produces exactly N stall cycles.
- MemReqM dropping in MEM_WAIT without an ack is a protocol violation. Behaviour is a continued wait (the FSM does not sample MemReqM in MEM_WAIT).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, reset to 0:
  - LoadStallCnt: increments on each lwStall cycle actually applied.
  - MemStallCnt: increments on each memStall cycle.
  - FlushCnt: increments on each PCSrcE flush applied.
- Each counter wraps at 2^32.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 → ForwardAE=10. Set RdM=0 → ForwardAE=01. Rs2E=0 with RdW=0 → ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly 1 cycle. The next cycle (RdE=0 bubble) all 0.
- Branch: PCSrcE=1 → FlushD=FlushE=1 for 1 cycle, no stalls. PCSrcE with ResultSrcE=01, RdE=Rs1D → flush only, FlushE=1, StallF=0.
- Memory wait: MemReqM=1, ack after 3 cycles → Stall*=FlushW=1 for exactly 3 cycles, 0 on the ack cycle. A same-cycle ack gives 0 stall cycles.
- Timeout: MEM_TIMEOUT=8, MemReqM=1, no ack → MemErr=1 after the 8th stall cycle, HALT holds. A late MemAckM has no effect. rst mid-HALT → RUN, MemErr=0.
- Reset mid-wait: assert rst asynchronously during MEM_WAIT → outputs immediately flush-only, state RUN after release. With HAZARD_PERF_CNT_EN, all counters read 0.
